// File: rtl/ram_readback_fsm_pkg.sv
// Shared definitions for the destination-RAM readback path: FSM state codes
// and default RAM geometry common to the scan FSM, the RAM and this reader.
package ram_readback_fsm_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] FETCH   = 3'd1;
   localparam logic [2:0] CAPTURE = 3'd2;
   localparam logic [2:0] HOLD    = 3'd3;
   localparam logic [2:0] FINISH  = 3'd4;

endpackage

// File: rtl/ram_readback_fsm_hold_timer.sv
// Loadable down-counter with a zero flag; paces how long each entry stays
// on the display. Load wins over decrement, and it never wraps below zero.
module hold_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ram_readback_fsm.sv
// Readback controller: walks the destination RAM from 0 to the latched entry
// count, holding each word on disp_data. Optional running sum: READBACK_SUM_EN.
module ram_readback_fsm
   import ram_readback_fsm_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int HOLD_CYCLES = 50_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              BTN,
   input  logic [ADDR_W:0]   count,
   input  logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] raddr,
   output logic              re,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   output logic              busy,
   output logic              done
`ifdef READBACK_SUM_EN
   ,
   output logic [DATA_W+ADDR_W:0] sum
`endif
);

   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam logic [ADDR_W:0] LIMIT_MAX = {1'b1, {ADDR_W{1'b0}}};

   logic [2:0]        r_state;
   logic [ADDR_W:0]   r_limit;
   logic [ADDR_W-1:0] r_raddr;
   logic [DATA_W-1:0] r_disp_data;
   logic              r_disp_valid;

   logic              w_start;
   logic              w_last;
   logic              w_hold_zero;
   logic [ADDR_W:0]   w_count_clamped;

   assign w_start         = (r_state == IDLE) && BTN;
   assign w_count_clamped = (count > LIMIT_MAX) ? LIMIT_MAX : count;
   assign w_last          = ({1'b0, r_raddr} == (r_limit - 1'b1));

   hold_timer #(
      .W (HW)
   ) u_hold_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (r_state == CAPTURE),
      .i_load_val (HW'(HOLD_CYCLES - 1)),
      .i_dec      (r_state == HOLD),
      .o_zero     (w_hold_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_limit      <= '0;
         r_raddr      <= '0;
         r_disp_data  <= '0;
         r_disp_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (BTN) begin
                  r_limit <= w_count_clamped;
                  r_raddr <= '0;
                  if (w_count_clamped == '0) begin
                     r_disp_valid <= 1'b0;
                     r_state      <= FINISH;
                  end else begin
                     r_state <= FETCH;
                  end
               end
            end
            FETCH: r_state <= CAPTURE;
            // rdata is the RAM's registered response to the FETCH-cycle read
            CAPTURE: begin
               r_disp_data  <= rdata;
               r_disp_valid <= 1'b1;
               r_state      <= HOLD;
            end
            HOLD: begin
               if (w_hold_zero) begin
                  if (w_last) begin
                     r_state <= FINISH;
                  end else begin
                     r_raddr <= r_raddr + 1'b1;
                     r_state <= FETCH;
                  end
               end
            end
            FINISH:  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef READBACK_SUM_EN
   logic [DATA_W+ADDR_W:0] r_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum <= '0;
      end else if (w_start) begin
         r_sum <= '0;
      end else if (r_state == CAPTURE) begin
         r_sum <= r_sum + {{(ADDR_W + 1){1'b0}}, rdata};
      end
   end

   assign sum = r_sum;
`endif

   assign raddr      = r_raddr;
   assign re         = (r_state == FETCH);
   assign disp_data  = r_disp_data;
   assign disp_valid = r_disp_valid;
   assign busy       = (r_state != IDLE);
   assign done       = (r_state == FINISH);

endmodule

// File: tb/tb_ram_readback_fsm.sv
// Self-checking bench for ram_readback_fsm (ADDR_W=2, HOLD_CYCLES=4) with a
// registered-read RAM model and a cycle-indexed reference of the expected trace.
module tb_ram_readback_fsm;

   localparam int AW    = 2;
   localparam int DW    = 8;
   localparam int HC    = 4;
   localparam int P     = HC + 2;
   localparam int DEPTH = 4;
   localparam int MAXN  = 64;

   typedef struct packed {
      logic [AW-1:0] raddr;
      logic          re;
      logic [DW-1:0] dd;
      logic          dv;
      logic          busy;
      logic          done;
   } obs_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          BTN;
   logic [AW:0]   count;
   logic [DW-1:0] rdata;
   logic [AW-1:0] raddr;
   logic          re;
   logic [DW-1:0] disp_data;
   logic          disp_valid;
   logic          busy;
   logic          done;
`ifdef READBACK_SUM_EN
   logic [DW+AW:0] sum;
   logic [DW+AW:0] tr_sum [MAXN];
`endif

   ram_readback_fsm #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .HOLD_CYCLES (HC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .BTN        (BTN),
      .count      (count),
      .rdata      (rdata),
      .raddr      (raddr),
      .re         (re),
      .disp_data  (disp_data),
      .disp_valid (disp_valid),
      .busy       (busy),
      .done       (done)
`ifdef READBACK_SUM_EN
      ,
      .sum        (sum)
`endif
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) if (re) rdata <= mem[raddr];

   int   checks = 0;
   int   passed = 0;
   obs_t tr [MAXN];
   logic [DW-1:0] m_dd = '0;
   logic          m_dv = 1'b0;

   function automatic int clamp_cnt(input logic [AW:0] cnt);
      return (int'(cnt) > DEPTH) ? DEPTH : int'(cnt);
   endfunction

   // Expected outputs n cycles after the accepted press, from the period rule.
   function automatic obs_t model_at(input int n, input int lim);
      obs_t e;
      int   j;
      e.busy = (n <= lim * P);
      e.done = (n == lim * P);
      e.re   = (lim > 0) && (n < lim * P) && (n % P == 0);
      if (lim == 0)        e.raddr = '0;
      else if (n < lim * P) e.raddr = AW'(n / P);
      else                 e.raddr = AW'(lim - 1);
      if (lim == 0) begin
         e.dd = m_dd;
         e.dv = 1'b0;
      end else if (n < 2) begin
         e.dd = m_dd;
         e.dv = m_dv;
      end else begin
         j = (n - 2) / P;
         if (j > lim - 1) j = lim - 1;
         e.dd = mem[j];
         e.dv = 1'b1;
      end
      return e;
   endfunction

   function automatic void model_commit(input int lim);
      if (lim > 0) begin
         m_dd = mem[lim - 1];
         m_dv = 1'b1;
      end else begin
         m_dv = 1'b0;
      end
   endfunction

   // Press BTN once and record outputs for ncyc cycles; noisy mode wiggles
   // BTN and count while busy and holds BTN through the FINISH cycle.
   task automatic run_press(input logic [AW:0] cnt, input bit noisy, input int ncyc);
      int lim;
      lim = clamp_cnt(cnt);
      @(negedge clk);
      BTN   = 1'b1;
      count = cnt;
      @(posedge clk);
      for (int n = 0; n < ncyc; n++) begin
         @(negedge clk);
         tr[n] = {raddr, re, disp_data, disp_valid, busy, done};
`ifdef READBACK_SUM_EN
         tr_sum[n] = sum;
`endif
         if (noisy && n < lim * P) begin
            BTN   = 1'($urandom);
            count = (AW + 1)'($urandom);
         end else if (noisy && n == lim * P) begin
            BTN = 1'b1;
         end else begin
            BTN = 1'b0;
         end
      end
      BTN = 1'b0;
      $display("readback count=%0d limit=%0d noisy=%0d cycles=%0d", cnt, lim, noisy, ncyc);
   endtask

   task automatic test_reset();
      obs_t got;
      got = {raddr, re, disp_data, disp_valid, busy, done};
      checks++;
      if (got !== '0) $display("FAIL reset_state got=%h required=%h", got, obs_t'(0));
      else passed++;
`ifdef READBACK_SUM_EN
      checks++;
      if (sum !== '0) $display("FAIL reset_sum got=%h required=0", sum);
      else passed++;
`endif
   endtask

   task automatic test_basic();
      int   lim;
      obs_t e;
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h5A;
      lim = 3;
      run_press(3'd3, 1'b0, lim * P + 3);
      for (int n = 0; n < lim * P + 3; n++) begin
         e = model_at(n, lim);
         checks++;
         if (tr[n] !== e) $display("FAIL basic n=%0d got=%h required=%h", n, tr[n], e);
         else passed++;
      end
      model_commit(lim);
   endtask

   task automatic test_empty();
      obs_t e;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      run_press(3'd0, 1'b0, 3);
      for (int n = 0; n < 3; n++) begin
         e = model_at(n, 0);
         checks++;
         if (tr[n] !== e) $display("FAIL empty n=%0d got=%h required=%h", n, tr[n], e);
         else passed++;
      end
      model_commit(0);
   endtask

   task automatic test_clamp();
      int   lim;
      obs_t e;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      lim = clamp_cnt(3'd7);
      run_press(3'd7, 1'b0, lim * P + 3);
      for (int n = 0; n < lim * P + 3; n++) begin
         e = model_at(n, lim);
         checks++;
         if (tr[n] !== e) $display("FAIL clamp n=%0d got=%h required=%h", n, tr[n], e);
         else passed++;
      end
      model_commit(lim);
   endtask

   task automatic test_noisy_inputs(input int iters);
      int          lim;
      logic [AW:0] cnt;
      bit          noisy;
      obs_t        e;
      for (int it = 0; it < iters; it++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
         cnt   = (AW + 1)'($urandom_range(0, 7));
         noisy = (it % 2 == 0) ? 1'b1 : 1'($urandom);
         lim   = clamp_cnt(cnt);
         run_press(cnt, noisy, lim * P + 3);
         for (int n = 0; n < lim * P + 3; n++) begin
            e = model_at(n, lim);
            checks++;
            if (tr[n] !== e) $display("FAIL noisy it=%0d n=%0d got=%h required=%h", it, n, tr[n], e);
            else passed++;
         end
         model_commit(lim);
      end
   endtask

   task automatic test_reset_mid();
      obs_t got;
      obs_t e;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      @(negedge clk);
      BTN   = 1'b1;
      count = 3'd3;
      @(posedge clk);
      @(negedge clk);
      BTN = 1'b0;
      repeat (P + 3) @(negedge clk);
      checks++;
      if (raddr !== 2'd1 || disp_data !== mem[1])
         $display("FAIL pre_reset_hold got raddr=%0d data=%h required raddr=1 data=%h", raddr, disp_data, mem[1]);
      else passed++;
      #1 rst = 1'b1;
      #1;
      got = {raddr, re, disp_data, disp_valid, busy, done};
      checks++;
      if (got !== '0) $display("FAIL async_reset got=%h required=%h", got, obs_t'(0));
      else passed++;
      @(negedge clk);
      rst  = 1'b0;
      m_dd = '0;
      m_dv = 1'b0;
      $display("readback aborted by reset during hold of entry 1");
      run_press(3'd3, 1'b0, 3 * P + 3);
      for (int n = 0; n < 3 * P + 3; n++) begin
         e = model_at(n, 3);
         checks++;
         if (tr[n] !== e) $display("FAIL restart n=%0d got=%h required=%h", n, tr[n], e);
         else passed++;
      end
      model_commit(3);
   endtask

`ifdef READBACK_SUM_EN
   task automatic test_sum();
      logic [DW+AW:0] exp_sum;
      mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'h01; mem[3] = 8'h77;
      run_press(3'd3, 1'b0, 3 * P + 3);
      checks++;
      if (tr_sum[3 * P] !== 11'h1FF) $display("FAIL sum_at_done got=%h required=%h", tr_sum[3 * P], 11'h1FF);
      else passed++;
      model_commit(3);
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      exp_sum = '0;
      for (int i = 0; i < 2; i++) exp_sum = exp_sum + (DW + AW + 1)'(mem[i]);
      run_press(3'd2, 1'b0, 2 * P + 3);
      checks++;
      if (tr_sum[0] !== '0) $display("FAIL sum_cleared_on_start got=%h required=0", tr_sum[0]);
      else passed++;
      checks++;
      if (tr_sum[2 * P + 2] !== exp_sum) $display("FAIL sum_second_run got=%h required=%h", tr_sum[2 * P + 2], exp_sum);
      else passed++;
      model_commit(2);
   endtask
`endif

   initial begin
      rst   = 1'b1;
      BTN   = 1'b0;
      count = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      test_basic();
      test_empty();
      test_clamp();
      test_noisy_inputs(6);
      test_reset_mid();
`ifdef READBACK_SUM_EN
      test_sum();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
